// File: rtl/alu_muldiv_seq_if.sv
// Handshake/bus bundle between the pipeline, the shared EX-stage ALU and the
// multi-cycle MUL/DIVU/REMU sequencer.
interface alu_muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             kill;
  logic [WIDTH-1:0] ex_in1;
  logic [WIDTH-1:0] ex_in2;
  logic [3:0]       ex_ctrl;
  logic [WIDTH-1:0] alu_out;
  logic [WIDTH-1:0] alu_in1;
  logic [WIDTH-1:0] alu_in2;
  logic [3:0]       alu_ctrl;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, op, opa, opb, kill, ex_in1, ex_in2, ex_ctrl, alu_out,
    input  alu_in1, alu_in2, alu_ctrl, stall, done, result
  );

  modport slave (
    input  start, op, opa, opb, kill, ex_in1, ex_in2, ex_ctrl, alu_out,
    output alu_in1, alu_in2, alu_ctrl, stall, done, result
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Iterative shift-add multiplier and restoring divider that borrow the
// pipeline's EX ALU for their add/subtract step, stalling the pipeline meanwhile.
module alu_muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  alu_muldiv_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REMU = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [1:0]       op_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0] mplier_reg;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] quot_reg;
  logic [WIDTH-1:0] result_reg;

  logic             is_mul;
  logic             running;
  logic [WIDTH:0]   r_shift;
  logic             take;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quot_next;

  // mplier_reg doubles as the divisor: it only shifts for MUL.
  always_comb begin
    is_mul    = (op_reg == OP_MUL);
    running   = (state_reg == RUN);
    r_shift   = {rem_reg, quot_reg[WIDTH-1]};
    take      = r_shift[WIDTH] | (r_shift[WIDTH-1:0] >= mplier_reg);
    acc_next  = mplier_reg[0] ? bus.alu_out : acc_reg;
    rem_next  = take ? bus.alu_out : r_shift[WIDTH-1:0];
    quot_next = {quot_reg[WIDTH-2:0], take};

    bus.alu_in1  = bus.ex_in1;
    bus.alu_in2  = bus.ex_in2;
    bus.alu_ctrl = bus.ex_ctrl;
    if (running) begin
      bus.alu_in1  = is_mul ? acc_reg : r_shift[WIDTH-1:0];
      bus.alu_in2  = is_mul ? mcand_reg : mplier_reg;
      bus.alu_ctrl = is_mul ? 4'h0 : 4'h1;
    end

    // Stall must rise in the very cycle start is seen so the pipeline holds the operands.
    bus.stall  = running | ((state_reg == IDLE) & bus.start & ~bus.kill);
    bus.done   = (state_reg == DONE) & ~bus.kill;
    bus.result = result_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      op_reg     <= OP_MUL;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      rem_reg    <= '0;
      quot_reg   <= '0;
      result_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start && !bus.kill) begin
            op_reg     <= bus.op;
            acc_reg    <= '0;
            mcand_reg  <= bus.opa;
            mplier_reg <= bus.opb;
            rem_reg    <= '0;
            quot_reg   <= bus.opa;
            cnt_reg    <= '0;
            if (bus.op == OP_RSVD) begin
              result_reg <= '0;
              state_reg  <= DONE;
            end else if ((bus.op == OP_DIVU || bus.op == OP_REMU) && bus.opb == '0) begin
              result_reg <= (bus.op == OP_DIVU) ? '1 : bus.opa;
              state_reg  <= DONE;
            end else begin
              state_reg  <= RUN;
            end
          end
        end
        RUN: begin
          if (bus.kill) begin
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
            if (is_mul) begin
              acc_reg    <= acc_next;
              mcand_reg  <= mcand_reg << 1;
              mplier_reg <= mplier_reg >> 1;
            end else begin
              rem_reg  <= rem_next;
              quot_reg <= quot_next;
            end
            // Capture from the _next values so the last iteration lands in the result.
            if (cnt_reg == CNT_LAST) begin
              state_reg  <= DONE;
              result_reg <= is_mul ? acc_next :
                            (op_reg == OP_DIVU) ? quot_next : rem_next;
            end
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq: models the shared ALU, runs a vector table through a
// result scoreboard, then hand-written kill/reset/held-start/pass-through sequences.
module tb_alu_muldiv_seq;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_muldiv_seq_if #(.WIDTH(W)) bus ();

  alu_muldiv_seq #(.WIDTH(W), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // External ALU: ADD, SUB, anything else XOR.
  assign bus.alu_out = (bus.alu_ctrl == 4'h0) ? bus.alu_in1 + bus.alu_in2 :
                       (bus.alu_ctrl == 4'h1) ? bus.alu_in1 - bus.alu_in2 :
                                                bus.alu_in1 ^ bus.alu_in2;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] sb_q[$];

  typedef struct {
    string        name;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    int           lat;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (op)
      2'b00:   return p[W-1:0];
      2'b01:   return (b == 0) ? {W{1'b1}} : a / b;
      2'b10:   return (b == 0) ? a : a % b;
      default: return '0;
    endcase
  endfunction

  task automatic run_op(input string name, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp, input int lat);
    int  n;
    bit  seen;
    bit  bad_ctrl;
    bit  bad_stall;
    logic [3:0] exp_ctrl;
    logic [W-1:0] e;
    exp_ctrl = (op == 2'b00) ? 4'h0 : 4'h1;
    sb_q.push_back(exp);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = op; bus.opa = a; bus.opb = b;
    @(negedge clk);
    check({name, "_stall_c0"}, 64'(bus.stall), 64'd1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 1; seen = 0; bad_ctrl = 0; bad_stall = 0;
    while (n <= 40 && !seen) begin
      @(negedge clk);
      if (bus.done) seen = 1;
      else begin
        if (!bus.stall) bad_stall = 1;
        if (bus.alu_ctrl !== exp_ctrl) bad_ctrl = 1;
        n++;
        if (n <= 40) @(posedge clk);
      end
    end
    e = sb_q.pop_front();
    check({name, "_latency"}, seen ? 64'(n) : 64'hDEAD, 64'(lat));
    if (seen) begin
      check({name, "_result"}, 64'(bus.result), 64'(e));
      check({name, "_stall_at_done"}, 64'(bus.stall), 64'd0);
      if (lat > 1) begin
        check({name, "_run_stall_low"}, 64'(bad_stall), 64'd0);
        check({name, "_run_ctrl"}, 64'(bad_ctrl), 64'd0);
      end
    end
  endtask

  initial begin
    int ndone;
    int first;
    logic [W-1:0] res;
    logic [1:0] rop;
    logic [W-1:0] ra, rb;

    vecs[0]  = '{"mul_7x6",      2'b00, 32'd7,          32'd6,          32'd42,         33};
    vecs[1]  = '{"mul_ffxff",    2'b00, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001,   33};
    vecs[2]  = '{"mul_ovf",      2'b00, 32'h00010000,   32'h00010000,   32'h00000000,   33};
    vecs[3]  = '{"divu_100_7",   2'b01, 32'd100,        32'd7,          32'd14,         33};
    vecs[4]  = '{"remu_100_7",   2'b10, 32'd100,        32'd7,          32'd2,          33};
    vecs[5]  = '{"divu_ff_1",    2'b01, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   33};
    vecs[6]  = '{"remu_8m_ff",   2'b10, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   33};
    vecs[7]  = '{"divu_55_0",    2'b01, 32'd55,         32'd0,          32'hFFFFFFFF,   1};
    vecs[8]  = '{"remu_55_0",    2'b10, 32'd55,         32'd0,          32'd55,         1};
    vecs[9]  = '{"rsvd",         2'b11, 32'd123,        32'd45,         32'd0,          1};
    vecs[10] = '{"divu_1000_33", 2'b01, 32'd1000,       32'd33,         32'd30,         33};

    rst = 1'b1;
    bus.start = 0; bus.op = 0; bus.opa = 0; bus.opb = 0; bus.kill = 0;
    bus.ex_in1 = 32'h1234; bus.ex_in2 = 32'h5678; bus.ex_ctrl = 4'h3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_done",   64'(bus.done),     64'd0);
    check("rst_stall",  64'(bus.stall),    64'd0);
    check("rst_result", 64'(bus.result),   64'd0);
    check("rst_in1",    64'(bus.alu_in1),  64'h1234);
    check("rst_in2",    64'(bus.alu_in2),  64'h5678);
    check("rst_ctrl",   64'(bus.alu_ctrl), 64'h3);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < NV; i++)
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    for (int i = 0; i < 4; i++) begin
      rop = 2'($urandom_range(0, 2));
      ra  = $urandom;
      rb  = (i == 3) ? 32'd0 : ((rop == 2'b00) ? $urandom : 32'($urandom_range(1, 5000)));
      run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, model(rop, ra, rb),
             (rop != 2'b00 && rb == 0) ? 1 : 33);
    end

    // kill during RUN
    @(posedge clk); #1;
    bus.start = 1; bus.op = 2'b00; bus.opa = 7; bus.opb = 6;
    @(posedge clk); #1;
    bus.start = 0;
    repeat (9) @(posedge clk);
    #1 bus.kill = 1;
    @(negedge clk);
    check("kill_done_c10",  64'(bus.done),  64'd0);
    check("kill_stall_c10", 64'(bus.stall), 64'd1);
    @(posedge clk); #1;
    bus.kill = 0; bus.ex_in1 = 32'hA5A5; bus.ex_in2 = 32'h0F0F; bus.ex_ctrl = 4'h7;
    @(negedge clk);
    check("kill_stall_c11", 64'(bus.stall),    64'd0);
    check("kill_in1_c11",   64'(bus.alu_in1),  64'hA5A5);
    check("kill_in2_c11",   64'(bus.alu_in2),  64'h0F0F);
    check("kill_ctrl_c11",  64'(bus.alu_ctrl), 64'h7);
    ndone = 0;
    repeat (40) begin @(negedge clk); if (bus.done) ndone++; end
    check("kill_no_done", 64'(ndone), 64'd0);

    // reset in the middle of a DIVU
    @(posedge clk); #1;
    bus.start = 1; bus.op = 2'b01; bus.opa = 100; bus.opb = 7;
    @(posedge clk); #1;
    bus.start = 0;
    repeat (19) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_done",   64'(bus.done),   64'd0);
    check("midrst_stall",  64'(bus.stall),  64'd0);
    check("midrst_result", 64'(bus.result), 64'd0);
    @(posedge clk); #1;
    rst = 0;
    ndone = 0;
    repeat (40) begin @(negedge clk); if (bus.done) ndone++; end
    check("midrst_no_done", 64'(ndone), 64'd0);

    // start held high through RUN and DONE with changing operands
    sb_q.push_back(model(2'b00, 32'd7, 32'd6));
    @(posedge clk); #1;
    bus.start = 1; bus.op = 2'b00; bus.opa = 7; bus.opb = 6;
    @(posedge clk); #1;
    bus.opa = 3; bus.opb = 3; bus.op = 2'b01;
    ndone = 0; first = -1; res = '0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (bus.done) begin
        ndone++;
        if (first < 0) begin first = n; res = bus.result; end
      end
      @(posedge clk); #1;
      if (ndone > 0) bus.start = 0;
    end
    check("held_done_count", 64'(ndone), 64'd1);
    check("held_done_cycle", 64'(first), 64'd33);
    check("held_result",     64'(res),   64'(sb_q.pop_front()));

    // pass-through in IDLE
    bus.ex_ctrl = 4'hB; bus.ex_in1 = 32'd5; bus.ex_in2 = 32'd9;
    @(negedge clk);
    check("pt_in1",   64'(bus.alu_in1),  64'd5);
    check("pt_in2",   64'(bus.alu_in2),  64'd9);
    check("pt_ctrl",  64'(bus.alu_ctrl), 64'hB);
    check("pt_stall", 64'(bus.stall),    64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Multi-cycle sequencer that shares the EX-stage 32-bit ALU between normal pipeline traffic and iterative MUL/DIVU/REMU operations.
- Owns the mux in front of the ALU's in1/in2/ctrl inputs and reads back the ALU output.
- Stalls the pipeline while an iterative op runs.
- Presents a one-cycle done pulse with the 32-bit result.

Parameters:
- WIDTH, 32, datapath width; must match the ALU.
- CNT_W, 5, iteration counter width; 2^CNT_W must equal WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request an iterative op; sampled only in IDLE.
- op  input  2  00=MUL (low word), 01=DIVU, 10=REMU, 11=reserved.
- opa  input  WIDTH  multiplicand / dividend.
- opb  input  WIDTH  multiplier / divisor.
- kill  input  1  pipeline flush; aborts the current op.
- ex_in1  input  WIDTH  pipeline ALU operand 1 (pass-through).
- ex_in2  input  WIDTH  pipeline ALU operand 2 (pass-through).
- ex_ctrl  input  4  pipeline ALU control (pass-through).
- alu_out  input  WIDTH  result returned from the shared ALU.
- alu_in1  output  WIDTH  to ALU in1.
- alu_in2  output  WIDTH  to ALU in2.
- alu_ctrl  output  4  to ALU ctrl.
- stall  output  1  hold IF/ID/EX registers.
- done  output  1  one-cycle result-valid pulse.
- result  output  WIDTH  op result; valid while done=1.

Behaviour:
- Reset state: IDLE, counter=0, internal acc/rem/quot/mcand/mplier=0.
- Reset outputs: done=0, stall=0, result=0, and the ALU mux in pass-through.
- Reset wins over every other input, including mid-op. There is no partial result and no done pulse.

States:
- IDLE:
  - ALU mux in pass-through.
  - start=1 and kill=0: stall=1 combinationally in the same cycle. Latch opa/opb/op and clear counter.
  - Next state is RUN, or DONE if op is DIVU/REMU and opb=0.
- RUN:
  - stall=1.
  - alu_in1/alu_in2/alu_ctrl are driven by the sequencer. ex_* are ignored.
  - counter increments each cycle. After the counter=WIDTH-1 iteration, go to DONE.
- DONE:
  - done=1 and result is valid for exactly one cycle.
  - stall=0 and the ALU mux is in pass-through.
  - Always returns to IDLE.
  - start in this cycle is ignored.

Latency:
- Normal op: start sampled in cycle 0, RUN in cycles 1..WIDTH, done in cycle WIDTH+1 (33).
- Divide-by-zero: done in cycle 1.

MUL iteration:
- Initial values: acc=0, mcand=opa, mplier=opb.
- Each cycle: alu_in1=acc, alu_in2=mcand, alu_ctrl=4'h0 (ADD).
- If mplier[0]=1 then acc<=alu_out, else acc is unchanged.
- Each cycle: mcand<=mcand<<1, mplier<=mplier>>1. Both shifts are internal.
- result = acc, modulo 2^WIDTH.

DIVU/REMU iteration (restoring):
- Initial values: rem=0, quot=opa.
- Each cycle:
  - r = {rem, quot[WIDTH-1]}, WIDTH+1 bits.
  - alu_in1 = r[WIDTH-1:0], alu_in2 = divisor, alu_ctrl = 4'h1 (SUB).
  - take = r[WIDTH] | (r[WIDTH-1:0] >= divisor), unsigned.
  - rem <= take ? alu_out : r[WIDTH-1:0].
  - quot <= {quot[WIDTH-2:0], take}.
- result: DIVU = quot, REMU = rem.

Divide by zero: DIVU result = all ones; REMU result = opa. No iterations.

Reserved op=11: skip RUN and go to DONE with result=0.

kill:
- In RUN or DONE: next state IDLE, no done pulse (done forced 0 that cycle), stall drops the next cycle.
- kill together with start in IDLE: start is ignored.

start while RUN/DONE: ignored. The held operands are unaffected.

ALU control codes driven by the sequencer are limited to 4'h0 and 4'h1. In pass-through, all three ALU inputs equal ex_* exactly, combinationally.

Test Plan:
- MUL opa=7, opb=6 -> stall=1 in cycles 0..32, done=1 in cycle 33, result=42; alu_ctrl=4'h0 throughout RUN.
- MUL opa=0xFFFFFFFF, opb=0xFFFFFFFF -> result=0x00000001. MUL opa=0x10000, opb=0x10000 -> result=0x00000000.
- DIVU 100/7 -> result=14; REMU 100/7 -> result=2; DIVU 0xFFFFFFFF/1 -> result=0xFFFFFFFF; REMU 0x80000000/0xFFFFFFFF -> result=0x80000000.
- DIVU 55/0 -> done in cycle 1, result=0xFFFFFFFF; REMU 55/0 -> result=55; stall high only in cycle 0.
- MUL started, kill at cycle 10 -> no done pulse, IDLE in cycle 11, alu_in1/in2/ctrl equal ex_* again; rst=1 at cycle 20 of a DIVU -> done=0, stall=0, result=0 in the next cycle.
- start held high through RUN with different operands -> exactly one done at cycle 33 with the original result. IDLE with ex_ctrl=4'hB, ex_in1=5, ex_in2=9 -> ALU ports mirror these exactly and stall=0.
